// File: rtl/uart_pkg.sv
// uart_pkg: receive FSM state type and shared helpers for the UART rx path.
// The parity step is built only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int PAR_MAX_W      = 32;

    // Parity bit a transmitter sends so that the total count of ones is even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rx_fifo_sync.sv
// rx_fifo_sync: single-clock first-word-fall-through FIFO.
// rdata shows the head entry, or zero while the FIFO is empty.
module rx_fifo_sync #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [FIFO_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [FIFO_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: oversampled UART receiver feeding an rx FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit before stop.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_tick,
    input  logic                  rx,
    input  logic                  ren,
    input  logic                  err_clr,
    output logic [FIFO_WIDTH-1:0] rd_data,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic                  rx_done,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(FIFO_WIDTH + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FIFO_WIDTH - 1);

    logic                  sync1_q;
    logic                  rx_s;
    rx_state_t             state_q;
    rx_state_t             state_d;
    logic [TW-1:0]         tick_q;
    logic [BW-1:0]         bit_q;
    logic [FIFO_WIDTH-1:0] shift_q;
    logic                  at_mid;
    logic                  at_last;
    logic                  tick_clr;
    logic                  tick_inc;
    logic                  bit_clr;
    logic                  shift_en;
    logic                  par_en;
    logic                  stop_evt;
    logic                  fifo_push;
    logic                  ferr_set;
    logic                  ovr_set;

    assign at_mid  = rx_tick && (tick_q == TICK_MID);
    assign at_last = rx_tick && (tick_q == TICK_LAST);

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s    <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rx_tick && !rx_s) state_d = START;
            end
            START: begin
                if (at_mid) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (at_last && (bit_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY: begin
                if (at_last) state_d = STOP;
            end
            STOP: begin
                if (at_last) state_d = rx_s ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: begin
                if (rx_tick && rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_clr = 1'b0;
        tick_inc = 1'b0;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_evt = 1'b0;
        unique case (state_q)
            START: begin
                tick_inc = rx_tick;
                tick_clr = at_mid;
                bit_clr  = at_mid;
            end
            DATA: begin
                tick_inc = rx_tick;
                tick_clr = at_last;
                shift_en = at_last;
            end
            PARITY: begin
                tick_inc = rx_tick;
                tick_clr = at_last;
                par_en   = at_last;
            end
            STOP: begin
                tick_inc = rx_tick;
                tick_clr = at_last;
                stop_evt = at_last;
            end
            default: tick_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            if (tick_clr) begin
                tick_q <= '0;
            end else if (tick_inc) begin
                tick_q <= tick_q + TW'(1);
            end
            if (bit_clr) begin
                bit_q <= '0;
            end else if (shift_en) begin
                bit_q <= bit_q + BW'(1);
            end
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[FIFO_WIDTH-1:1]};
            end
        end
    end

    // Full is judged before any same-cycle pop, so a racing ren never makes room.
    assign fifo_push = stop_evt && rx_s && !rx_full;
    assign ferr_set  = stop_evt && !rx_s;
    assign ovr_set   = stop_evt && rx_s && rx_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_done <= stop_evt;
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q;
    logic perr_set;

    assign perr_set = stop_evt && rx_s && perr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q     <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_en) begin
                perr_q <= even_parity(PAR_MAX_W'(shift_q)) ^ rx_s;
            end
            if (perr_set) begin
                parity_err <= 1'b1;
            end else if (err_clr) begin
                parity_err <= 1'b0;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    rx_fifo_sync #(
        .FIFO_WIDTH(FIFO_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .wdata(shift_q),
        .pop  (ren),
        .rdata(rd_data),
        .full (rx_full),
        .empty(rx_empty)
    );

endmodule
